// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time to a
// variable-latency instruction memory, and feeds the IF/ID register through a one-entry skid buffer.
`timescale 1ns/1ps

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// FETCH | request outstanding at imem_addr
// HOLD  | decode stalled, fetched word parked in skid buffer, no request
// DRAIN | redirected while a request was outstanding; discard its data
module if_fetch_stage #(
    parameter int                   ADDR_W    = 16,
    parameter int                   WORD_LEN  = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [WORD_LEN-1:0]  NOP_INSTR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_detected,
    input  logic                 brTaken,
    input  logic [ADDR_W-1:0]    br_target,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_LEN-1:0]  imem_rdata,
    output logic [WORD_LEN-1:0]  instruction,
    output logic [ADDR_W-1:0]    pc_ID,
    output logic                 valid_ID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_W-1:0]     pc;
    logic [WORD_LEN-1:0]   skid_data;
    logic [ADDR_W-1:0]     skid_addr;
    logic                  skid_valid;
    logic                  slot_accept;
    logic [ADDR_W-1:0]     addr_next;

    assign slot_accept = !hazard_detected || !valid_ID;
    assign addr_next   = imem_addr + 1'b1;
    assign imem_req    = (state == FETCH) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_ID       <= '0;
            valid_ID    <= 1'b0;
            skid_data   <= NOP_INSTR;
            skid_addr   <= '0;
            skid_valid  <= 1'b0;
        end else if (brTaken) begin
            // Redirect wins over stall and capture; only the outstanding request survives.
            valid_ID    <= 1'b0;
            instruction <= NOP_INSTR;
            skid_valid  <= 1'b0;
            pc          <= br_target;
            case (state)
                IDLE, HOLD: begin
                    imem_addr <= br_target;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        imem_addr <= br_target;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_addr <= br_target;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    imem_addr <= pc;
                    state     <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc <= addr_next;
                        if (slot_accept) begin
                            instruction <= imem_rdata;
                            pc_ID       <= imem_addr;
                            valid_ID    <= 1'b1;
                            imem_addr   <= addr_next;
                        end else begin
                            skid_data  <= imem_rdata;
                            skid_addr  <= imem_addr;
                            skid_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (!hazard_detected) begin
                        valid_ID    <= 1'b0;
                        instruction <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (slot_accept) begin
                        instruction <= skid_data;
                        pc_ID       <= skid_addr;
                        valid_ID    <= skid_valid;
                        skid_valid  <= 1'b0;
                        imem_addr   <= pc;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        imem_addr <= pc;
                        state     <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a latency-programmable memory model, a scoreboard of
// expected IF/ID transfers, and a second instance with RESET_PC near the top of the address space.
`timescale 1ns/1ps

module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        hazard_detected;
    logic        brTaken;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [15:0] pc_ID;
    logic        valid_ID;

    logic        rst_w;
    logic        hazard_w;
    logic        br_w;
    logic [15:0] br_target_w;
    logic        imem_req_w;
    logic [15:0] imem_addr_w;
    logic        imem_ack_w;
    logic [15:0] imem_rdata_w;
    logic [15:0] instruction_w;
    logic [15:0] pc_ID_w;
    logic        valid_ID_w;

    int checks   = 0;
    int failures = 0;
    int lat      = 0;
    logic [31:0] exp_q[$];

    if_fetch_stage #(.ADDR_W(16), .WORD_LEN(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .brTaken(brTaken),
        .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instruction(instruction), .pc_ID(pc_ID), .valid_ID(valid_ID)
    );

    if_fetch_stage #(.ADDR_W(16), .WORD_LEN(16), .RESET_PC(16'hFFFE), .NOP_INSTR(16'h0000)) u_dut_wrap (
        .clk(clk), .rst(rst_w), .hazard_detected(hazard_w), .brTaken(br_w),
        .br_target(br_target_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
        .imem_rdata(imem_rdata_w), .instruction(instruction_w), .pc_ID(pc_ID_w), .valid_ID(valid_ID_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrap instance: zero-wait memory, never stalled or redirected.
    assign hazard_w     = 1'b0;
    assign br_w         = 1'b0;
    assign br_target_w  = 16'h0000;
    assign imem_ack_w   = 1'b1;
    assign imem_rdata_w = 16'h1000 + imem_addr_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after `lat` wait cycles of a held request; data = 0x1000 + address.
    initial begin
        int  cnt;
        logic prev_done;
        logic prev_req;
        cnt = 0; prev_done = 1'b0; prev_req = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cnt = 0; prev_done = 1'b0; prev_req = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (prev_done) cnt = 0;
                else if (prev_req) cnt++;
                imem_ack   = imem_req && (cnt == lat);
                imem_rdata = imem_ack ? 16'h1000 + imem_addr : 16'hDEAD;
                prev_done  = imem_ack;
                prev_req   = imem_req;
            end
        end
    end

    // Monitor: decode takes the IF/ID contents on each edge where valid and not stalled.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && valid_ID && !hazard_detected) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got instr %h pc %h expected nothing at %0t",
                             instruction, pc_ID, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({instruction, pc_ID} !== e) begin
                        failures++;
                        $display("FAIL sb_transfer: got instr %h pc %h expected instr %h pc %h at %0t",
                                 instruction, pc_ID, e[31:16], e[15:0], $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; rst_w = 1'b0;
        hazard_detected = 1'b0; brTaken = 1'b0; br_target = 16'h0000;

        exp_q.push_back({16'h1000, 16'h0000});
        exp_q.push_back({16'h1001, 16'h0001});
        exp_q.push_back({16'h1002, 16'h0002});
        exp_q.push_back({16'h1003, 16'h0003});
        exp_q.push_back({16'h1004, 16'h0004});
        exp_q.push_back({16'h1040, 16'h0040});
        exp_q.push_back({16'h1080, 16'h0080});

        repeat (2) @(negedge clk);
        #2;
        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_valid", 32'(valid_ID),    32'd0);
        check("rst_instr", 32'(instruction), 32'h0);
        check("rst_pc_id", 32'(pc_ID),       32'h0);
        check("rst_addr",  32'(imem_addr),   32'h0);
        check("rst_addr_w", 32'(imem_addr_w), 32'hFFFE);

        for (int c = 0; c <= 35; c++) begin
            @(negedge clk);
            case (c)
                0:  begin rst = 1'b1; rst_w = 1'b1; end
                4:  hazard_detected = 1'b1;
                8:  hazard_detected = 1'b0;
                10: begin brTaken = 1'b1; br_target = 16'h0040; end
                11: brTaken = 1'b0;
                22: hazard_detected = 1'b1;
                26: begin brTaken = 1'b1; br_target = 16'h0080; end
                27: begin brTaken = 1'b0; hazard_detected = 1'b0; end
                32: hazard_detected = 1'b1;
                default: ;
            endcase
            #2;
            case (c)
                1: begin
                    check("first_req",    32'(imem_req),    32'd1);
                    check("addr_c1",      32'(imem_addr),   32'h0);
                    check("wrap_addr_c1", 32'(imem_addr_w), 32'hFFFE);
                end
                2: begin
                    check("addr_c2",       32'(imem_addr),     32'h1);
                    check("valid_c2",      32'(valid_ID),      32'd1);
                    check("instr_c2",      32'(instruction),   32'h1000);
                    check("wrap_addr_c2",  32'(imem_addr_w),   32'hFFFF);
                    check("wrap_instr_c2", 32'(instruction_w), 32'h0FFE);
                    check("wrap_valid_c2", 32'(valid_ID_w),    32'd1);
                end
                3: begin
                    check("addr_c3",       32'(imem_addr),     32'h2);
                    check("wrap_addr_c3",  32'(imem_addr_w),   32'h0000);
                    check("wrap_pc_c3",    32'(pc_ID_w),       32'hFFFF);
                end
                4: begin
                    check("addr_c4",       32'(imem_addr),     32'h3);
                    check("wrap_instr_c4", 32'(instruction_w), 32'h1000);
                    check("wrap_pc_c4",    32'(pc_ID_w),       32'h0000);
                end
                5, 7: begin
                    check("hold_req",   32'(imem_req),    32'd0);
                    check("hold_instr", 32'(instruction), 32'h1002);
                    check("hold_valid", 32'(valid_ID),    32'd1);
                end
                9: begin
                    check("resume_addr",  32'(imem_addr),   32'h4);
                    check("resume_instr", 32'(instruction), 32'h1003);
                    check("resume_pc",    32'(pc_ID),       32'h3);
                    lat = 3;
                end
                10: check("instr_c10", 32'(instruction), 32'h1004);
                11: begin
                    check("drain_valid", 32'(valid_ID),    32'd0);
                    check("drain_instr", 32'(instruction), 32'h0);
                    check("drain_req",   32'(imem_req),    32'd1);
                    check("drain_addr",  32'(imem_addr),   32'h5);
                end
                13: check("drain_addr_c13", 32'(imem_addr), 32'h5);
                14: begin
                    check("redir_addr",  32'(imem_addr),   32'h40);
                    check("late_discard", 32'(instruction), 32'h0);
                end
                15: check("lat_addr_c15", 32'(imem_addr), 32'h40);
                18: begin
                    check("instr_1040", 32'(instruction), 32'h1040);
                    check("pc_40",      32'(pc_ID),       32'h40);
                    check("addr_41",    32'(imem_addr),   32'h41);
                end
                19: check("slot_drain_c19", 32'(valid_ID), 32'd0);
                21: begin
                    check("lat_addr_c21", 32'(imem_addr), 32'h41);
                    check("lat_req_c21",  32'(imem_req),  32'd1);
                end
                22: begin
                    check("instr_1041", 32'(instruction), 32'h1041);
                    check("pc_41",      32'(pc_ID),       32'h41);
                end
                26: begin
                    check("hold2_req",   32'(imem_req),    32'd0);
                    check("hold2_instr", 32'(instruction), 32'h1041);
                end
                27: begin
                    check("flush_valid", 32'(valid_ID),    32'd0);
                    check("flush_instr", 32'(instruction), 32'h0);
                    check("flush_addr",  32'(imem_addr),   32'h80);
                    check("flush_req",   32'(imem_req),    32'd1);
                end
                31: begin
                    check("instr_1080", 32'(instruction), 32'h1080);
                    check("pc_80",      32'(pc_ID),       32'h80);
                end
                32: begin
                    check("empty_valid", 32'(valid_ID),    32'd0);
                    check("empty_instr", 32'(instruction), 32'h0);
                end
                35: begin
                    check("instr_1081", 32'(instruction), 32'h1081);
                    check("addr_82",    32'(imem_addr),   32'h82);
                    check("req_82",     32'(imem_req),    32'd1);
                end
                default: ;
            endcase
        end

        // Asynchronous reset mid-request, away from any clock edge.
        #1;
        rst = 1'b0;
        #1;
        check("async_req",   32'(imem_req),    32'd0);
        check("async_valid", 32'(valid_ID),    32'd0);
        check("async_instr", 32'(instruction), 32'h0);
        check("async_addr",  32'(imem_addr),   32'h0);
        check("async_pc_id", 32'(pc_ID),       32'h0);

        repeat (2) @(negedge clk);
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
